match_counter_display: RTL and testbench

Downstream consumer of the overlapping "1100" Moore sequence detector. Counts detection events signalled on the detector's `z` output in a 4-digit BCD counter (0000–9999), and drives a time-multiplexed, active-low 4-digit seven-segment display with leading-zero blanking. It also provides a sticky overflow flag. Sits between the detector and the board display pins in the lab 7 top level.

---
 rtl/lab7_pkg.sv | 19 +
 rtl/bcd_to_seg.sv | 30 +++
 rtl/match_counter_display.sv | 104 ++++++++++
 tb/tb_match_counter_display.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/lab7_pkg.sv
// lab7_pkg: shared display constants for the lab 7 match counter
package lab7_pkg;

    localparam int NUM_DIGITS = 4;

    // Active-low segment codes, bit 0 = a ... bit 6 = g
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg.sv
// bcd_to_seg: combinational BCD digit to active-low seven-segment decoder with blanking
module bcd_to_seg
    import lab7_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    // Decode one digit; blank or non-BCD input turns every segment off
    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/match_counter_display.sv
// match_counter_display: counts detector rising edges in 4-digit BCD and scans them onto a 7-seg display
module match_counter_display
    import lab7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        z,
    input  logic        clr,
    output logic [15:0] count_bcd,
    output logic        ovf,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam logic [RW-1:0] LAST = RW'(REFRESH_DIV - 1);

    logic          z_q;
    logic [15:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [RW-1:0] refresh_q, refresh_d;
    logic [1:0]    idx_q, idx_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          dp_q, dp_d;
    logic          carry;
    logic [3:0]    cur_digit;
    logic          cur_blank;

    // BCD ripple counter: a rising edge of z carries into the units digit, clr wins over it
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        carry   = z & ~z_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    count_d[4*i +: 4] = 4'd0;
                end else begin
                    count_d[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        if (carry) ovf_d = 1'b1;
        if (clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end
    end

    // Refresh divider and digit index; only reset affects the scan
    always_comb begin
        refresh_d = (refresh_q == LAST) ? '0 : refresh_q + 1'b1;
        idx_d     = (refresh_q == LAST) ? idx_q + 2'd1 : idx_q;
    end

    // Select the scanned digit; a digit blanks when it and all higher digits are zero
    always_comb begin
        cur_digit = count_q[{idx_q, 2'b00} +: 4];
        cur_blank = (idx_q != 2'd0) && ((count_q >> {idx_q, 2'b00}) == 16'h0000);
        an_d      = ~(4'b0001 << idx_q);
        dp_d      = ~(ovf_q && idx_q == 2'd3);
    end

    bcd_to_seg u_dec (
        .bcd   (cur_digit),
        .blank (cur_blank),
        .seg   (seg_d)
    );

    // State and registered display outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            z_q       <= 1'b0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            refresh_q <= '0;
            idx_q     <= 2'd0;
            seg_q     <= SEG_0;
            an_q      <= 4'b1110;
            dp_q      <= 1'b1;
        end else begin
            z_q       <= z;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            refresh_q <= refresh_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            dp_q      <= dp_d;
        end
    end

    assign count_bcd = count_q;
    assign ovf       = ovf_q;
    assign seg       = seg_q;
    assign an        = an_q;
    assign dp        = dp_q;

endmodule

// File: tb/tb_match_counter_display.sv
// tb_match_counter_display: randomized and directed checks against a decimal-arithmetic model
module tb_match_counter_display;

    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        z;
    logic        clr;
    logic [15:0] count_bcd;
    logic        ovf;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [6:0] TSEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                         7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                         7'b0000000, 7'b0010000};

    always #5 clk = ~clk;

    match_counter_display #(.REFRESH_DIV(RD)) dut (
        .clk       (clk),
        .reset     (reset),
        .z         (z),
        .clr       (clr),
        .count_bcd (count_bcd),
        .ovf       (ovf),
        .seg       (seg),
        .an        (an),
        .dp        (dp)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    function automatic int idx_of(input int ticks);
        return (ticks / RD) % 4;
    endfunction

    function automatic logic [6:0] exp_seg(input int cnt, input int i);
        int p;
        p = 10 ** i;
        if (i > 0 && cnt < p) return 7'b1111111;
        return TSEG[(cnt / p) % 10];
    endfunction

    // Behavioural model: decimal count, edges since reset, lagged display
    int         m_cnt;
    int         m_ticks;
    bit         m_ovf;
    bit         m_zprev;
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic       e_dp;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cnt   <= 0;
            m_ovf   <= 1'b0;
            m_zprev <= 1'b0;
            m_ticks <= 0;
            e_seg   <= TSEG[0];
            e_an    <= 4'b1110;
            e_dp    <= 1'b1;
        end else begin
            e_seg   <= exp_seg(m_cnt, idx_of(m_ticks));
            e_an    <= ~(4'b0001 << idx_of(m_ticks));
            e_dp    <= !(m_ovf && idx_of(m_ticks) == 3);
            m_zprev <= z;
            m_ticks <= m_ticks + 1;
            if (clr) begin
                m_cnt <= 0;
                m_ovf <= 1'b0;
            end else if (z && !m_zprev) begin
                if (m_cnt == 9999) begin
                    m_cnt <= 0;
                    m_ovf <= 1'b1;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("count_bcd", count_bcd, to_bcd(m_cnt));
        check("ovf", ovf, m_ovf);
        check("seg", seg, e_seg);
        check("an", an, e_an);
        check("dp", dp, e_dp);
    end

    task automatic step(input logic zv, input logic cv);
        @(negedge clk);
        z   = zv;
        clr = cv;
    endtask

    task automatic pulses(input int n);
        repeat (n) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
        end
    endtask

    logic [3:0] an_hist  [18];
    logic [6:0] seg_hist [18];
    logic [6:0] seen     [4];
    int         dp_ok;
    int         dp_bad;
    int         w;

    initial begin
        reset = 1'b0;
        z     = 1'b0;
        clr   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_count", count_bcd, 16'h0000);
        check("rst_ovf", ovf, 1'b0);
        check("rst_an", an, 4'b1110);
        check("rst_seg", seg, 7'b1000000);
        check("rst_dp", dp, 1'b1);
        reset = 1'b1;
        for (int k = 1; k < 18; k++) begin
            @(negedge clk);
            an_hist[k]  = an;
            seg_hist[k] = seg;
        end
        check("scan_an4", an_hist[4], 4'b1110);
        check("scan_an5", an_hist[5], 4'b1101);
        check("scan_an9", an_hist[9], 4'b1011);
        check("scan_an13", an_hist[13], 4'b0111);
        check("scan_an17", an_hist[17], 4'b1110);
        check("scan_seg1", seg_hist[1], 7'b1000000);
        check("scan_seg9", seg_hist[9], 7'b1111111);
        check("scan_seg13", seg_hist[13], 7'b1111111);

        pulses(3);
        step(1'b0, 1'b0);
        check("three_pulses", count_bcd, 16'h0003);
        repeat (10) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("held_z", count_bcd, 16'h0004);

        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        check("clr", count_bcd, 16'h0000);
        pulses(99);
        step(1'b0, 1'b0);
        check("preload99", count_bcd, 16'h0099);
        pulses(1);
        step(1'b0, 1'b0);
        check("count100", count_bcd, 16'h0100);
        for (int i = 0; i < 4; i++) seen[i] = 7'h00;
        repeat (16) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) if (an == ~(4'b0001 << i)) seen[i] = seg;
        end
        check("disp100_d0", seen[0], 7'b1000000);
        check("disp100_d1", seen[1], 7'b1000000);
        check("disp100_d2", seen[2], 7'b1111001);
        check("disp100_d3", seen[3], 7'b1111111);

        step(1'b0, 1'b1);
        pulses(10000);
        step(1'b0, 1'b0);
        check("wrap_count", count_bcd, 16'h0000);
        check("wrap_ovf", ovf, 1'b1);
        dp_ok  = 0;
        dp_bad = 0;
        repeat (16) begin
            @(negedge clk);
            if (dp == 1'b0 && an == 4'b0111) dp_ok++;
            if (dp == 1'b0 && an != 4'b0111) dp_bad++;
        end
        check("dp_thousands_lit", dp_ok != 0, 1'b1);
        check("dp_elsewhere_off", dp_bad, 0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("clr_ovf", ovf, 1'b0);
        check("clr_dp", dp, 1'b1);

        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        check("clr_beats_event", count_bcd, 16'h0000);
        pulses(1);
        step(1'b0, 1'b0);
        check("after_clr_event", count_bcd, 16'h0001);

        repeat (3000) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 31) == 0));

        step(1'b0, 1'b1);
        pulses(57);
        step(1'b0, 1'b0);
        check("preload57", count_bcd, 16'h0057);
        w = 0;
        while (idx_of(m_ticks) != 2 && w < 20) begin
            step(1'b0, 1'b0);
            w++;
        end
        check("reach_idx2", w < 20, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("async_count", count_bcd, 16'h0000);
        check("async_ovf", ovf, 1'b0);
        check("async_an", an, 4'b1110);
        check("async_seg", seg, 7'b1000000);
        check("async_dp", dp, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        repeat (40) step(1'b0, 1'b0);
        repeat (500) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 63) == 0));
        step(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
